// File: rtl/memory_layer_winner_search.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_layer_winner_search: scans one class of node memory for the two     |
// | nodes closest (L1) to an input vector and requests their connection.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module memory_layer_winner_search #(
   parameter int NODE_COUNT = 8,
   parameter int DIM        = 2,
   parameter int DATA_W     = 8,
   parameter int DIST_W     = DATA_W + $clog2(DIM) + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    learning_done,
   input  logic [31:0]             class_in,
   input  logic [DIM*DATA_W-1:0]   x_in,
   output logic                    rd_en,
   output logic [31:0]             rd_node,
   output logic [31:0]             rd_class,
   input  logic [DIM*DATA_W-1:0]   rd_data,
   input  logic                    rd_node_valid,
   output logic [31:0]             node1,
   output logic [31:0]             node2,
   output logic [31:0]             class_i,
   output logic                    en_connection,
   output logic                    busy,
   output logic                    done,
   output logic                    no_pair,
   output logic [DIST_W-1:0]       dist1
);

   localparam logic [31:0] c_LAST_NODE = 32'(NODE_COUNT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SCAN   = 2'd1,
      S_DRAIN  = 2'd2,
      S_REPORT = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [31:0]             r_class;
   logic [DIM*DATA_W-1:0]   r_x;
   logic [31:0]             r_idx;
   logic                    r_rsp_valid;
   logic [31:0]             r_rsp_node;
   logic [31:0]             r_best_idx;
   logic [DIST_W-1:0]       r_best_dist;
   logic [31:0]             r_sec_idx;
   logic [DIST_W-1:0]       r_sec_dist;

   logic                    w_accept;
   logic [DATA_W-1:0]       w_diff;
   logic [DIST_W-1:0]       w_dist;
   logic [31:0]             w_best_idx_n;
   logic [DIST_W-1:0]       w_best_dist_n;
   logic [31:0]             w_sec_idx_n;
   logic [DIST_W-1:0]       w_sec_dist_n;

   assign w_accept = start && !learning_done;

   always_comb begin
      w_state_nxt = r_state;
      rd_en       = 1'b0;
      rd_node     = '0;
      rd_class    = '0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_nxt = S_SCAN;
         end
         S_SCAN: begin
            rd_en    = 1'b1;
            rd_node  = r_idx;
            rd_class = r_class;
            busy     = 1'b1;
            if (r_idx == c_LAST_NODE) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            busy        = 1'b1;
            w_state_nxt = S_REPORT;
         end
         S_REPORT: begin
            busy        = 1'b1;
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // L1 distance; DIST_W leaves headroom so the sum never wraps.
   always_comb begin
      w_diff = '0;
      w_dist = '0;
      for (int d = 0; d < DIM; d++) begin
         if (r_x[d*DATA_W +: DATA_W] >= rd_data[d*DATA_W +: DATA_W])
            w_diff = r_x[d*DATA_W +: DATA_W] - rd_data[d*DATA_W +: DATA_W];
         else
            w_diff = rd_data[d*DATA_W +: DATA_W] - r_x[d*DATA_W +: DATA_W];
         w_dist = w_dist + DIST_W'(w_diff);
      end
   end

   // Top-two insertion; strict compares keep the earlier (lower) index on ties.
   always_comb begin
      w_best_idx_n  = r_best_idx;
      w_best_dist_n = r_best_dist;
      w_sec_idx_n   = r_sec_idx;
      w_sec_dist_n  = r_sec_dist;
      if (r_rsp_valid && rd_node_valid) begin
         if (w_dist < r_best_dist) begin
            w_sec_idx_n   = r_best_idx;
            w_sec_dist_n  = r_best_dist;
            w_best_idx_n  = r_rsp_node;
            w_best_dist_n = w_dist;
         end else if (w_dist < r_sec_dist) begin
            w_sec_idx_n  = r_rsp_node;
            w_sec_dist_n = w_dist;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_class       <= '0;
         r_x           <= '0;
         r_idx         <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_node    <= '0;
         r_best_idx    <= '0;
         r_best_dist   <= '1;
         r_sec_idx     <= '0;
         r_sec_dist    <= '1;
         node1         <= '0;
         node2         <= '0;
         class_i       <= '0;
         dist1         <= '0;
         en_connection <= 1'b0;
         no_pair       <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_rsp_valid   <= rd_en;
         r_rsp_node    <= rd_node;
         en_connection <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_class     <= class_in;
                  r_x         <= x_in;
                  r_idx       <= 32'd1;
                  r_best_idx  <= '0;
                  r_best_dist <= '1;
                  r_sec_idx   <= '0;
                  r_sec_dist  <= '1;
               end
            end
            S_SCAN: begin
               r_idx       <= r_idx + 32'd1;
               r_best_idx  <= w_best_idx_n;
               r_best_dist <= w_best_dist_n;
               r_sec_idx   <= w_sec_idx_n;
               r_sec_dist  <= w_sec_dist_n;
            end
            S_DRAIN: begin
               // Last response is folded in here so the report is registered on REPORT entry.
               r_best_idx  <= w_best_idx_n;
               r_best_dist <= w_best_dist_n;
               r_sec_idx   <= w_sec_idx_n;
               r_sec_dist  <= w_sec_dist_n;
               if (w_sec_idx_n != 32'd0) begin
                  en_connection <= 1'b1;
                  node1         <= w_best_idx_n;
                  node2         <= w_sec_idx_n;
                  class_i       <= r_class;
                  dist1         <= w_best_dist_n;
                  no_pair       <= 1'b0;
               end else begin
                  no_pair <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_memory_layer_winner_search.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memory_layer_winner_search: scoreboard bench with a node-memory model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_memory_layer_winner_search;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        learning_done = 1'b0;
   logic [31:0] class_in = '0;
   logic [15:0] x_in = '0;
   logic        rd_en;
   logic [31:0] rd_node, rd_class;
   logic [15:0] rd_data = '0;
   logic        rd_node_valid = 1'b0;
   logic [31:0] node1, node2, class_i;
   logic        en_connection, busy, done, no_pair;
   logic [9:0]  dist1;

   memory_layer_winner_search dut (
      .clk(clk), .rst_n(rst_n), .start(start), .learning_done(learning_done),
      .class_in(class_in), .x_in(x_in), .rd_en(rd_en), .rd_node(rd_node),
      .rd_class(rd_class), .rd_data(rd_data), .rd_node_valid(rd_node_valid),
      .node1(node1), .node2(node2), .class_i(class_i),
      .en_connection(en_connection), .busy(busy), .done(done),
      .no_pair(no_pair), .dist1(dist1)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          pair;
      logic [31:0] n1, n2, cls;
      logic [9:0]  d1;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          wa[N], wb[N];
   bit          vm[N];
   logic [31:0] prev_n1 = 0, prev_n2 = 0, prev_cls = 0;
   logic [9:0]  prev_d1 = 0;
   logic [31:0] cur_class = 0;
   int          exp_rd_node = 1;
   logic [15:0] pend_data = '0;
   logic        pend_valid = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Node memory: data for a read appears in the following cycle.
   always @(negedge clk) begin
      rd_data       = pend_data;
      rd_node_valid = pend_valid;
      pend_valid    = 1'b0;
      pend_data     = '0;
      if (rd_en) begin
         check("rd_node", rd_node, exp_rd_node);
         check("rd_class", rd_class, cur_class);
         exp_rd_node++;
         if (rd_node < N) begin
            pend_data  = {wb[rd_node][7:0], wa[rd_node][7:0]};
            pend_valid = vm[rd_node];
         end
      end
   end

   // Monitor: compares every completion against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done) begin
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
         end else begin
            e = sb_q.pop_front();
            check("en_connection", en_connection, e.pair);
            check("no_pair", no_pair, !e.pair);
            check("node1", node1, e.n1);
            check("node2", node2, e.n2);
            check("class_i", class_i, e.cls);
            check("dist1", dist1, e.d1);
         end
      end else if (en_connection) begin
         errors++;
         $display("FAIL en_without_done: got en_connection=1 expected 0 at %0t", $time);
      end
   end

   // Reference: winner is the smallest distance (lowest index among equals),
   // runner-up the same rule over the remaining valid nodes.
   function automatic exp_t model(input int x0, input int x1, input logic [31:0] cls);
      exp_t e;
      int   d[N];
      int   dmin, w1, w2;
      w1 = 0; w2 = 0;
      for (int n = 1; n < N; n++) begin
         d[n] = (x0 > wa[n] ? x0 - wa[n] : wa[n] - x0) + (x1 > wb[n] ? x1 - wb[n] : wb[n] - x1);
      end
      dmin = 1 << 20;
      for (int n = 1; n < N; n++) if (vm[n] && d[n] < dmin) dmin = d[n];
      for (int n = N - 1; n >= 1; n--) if (vm[n] && d[n] == dmin) w1 = n;
      dmin = 1 << 20;
      for (int n = 1; n < N; n++) if (vm[n] && n != w1 && d[n] < dmin) dmin = d[n];
      for (int n = N - 1; n >= 1; n--) if (vm[n] && n != w1 && d[n] == dmin) w2 = n;
      if (w2 != 0) begin
         prev_n1 = w1; prev_n2 = w2; prev_cls = cls; prev_d1 = 10'(d[w1]);
      end
      e.pair = (w2 != 0);
      e.n1 = prev_n1; e.n2 = prev_n2; e.cls = prev_cls; e.d1 = prev_d1;
      return e;
   endfunction

   task automatic fill(input int a, input int b, input bit v);
      for (int n = 0; n < N; n++) begin
         wa[n] = a; wb[n] = b; vm[n] = v;
      end
   endtask

   task automatic set_node(input int n, input int a, input int b, input bit v);
      wa[n] = a; wb[n] = b; vm[n] = v;
   endtask

   // Issues one search; optionally pokes start/learning_done mid-search.
   task automatic run_search(input int x0, input int x1, input logic [31:0] cls, input bit poke);
      int found;
      sb_q.push_back(model(x0, x1, cls));
      @(negedge clk);
      cur_class   = cls;
      exp_rd_node = 1;
      class_in    = cls;
      x_in        = {8'(x1), 8'(x0)};
      start       = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (done) begin
            found = cyc;
            break;
         end
         start = poke && (cyc == 3);
         if (poke && cyc == 4) learning_done = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      learning_done = 1'b0;
      check("latency", found, 9);
      @(negedge clk);
      check("idle_after", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int x0, x1;
      bit bad;
      #2;
      check("reset_outs", {node1, node2, class_i, dist1, en_connection, done, busy, no_pair, rd_en, rd_node, rd_class}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed: winner exact match, runner-up w2.
      fill(200, 200, 1);
      set_node(2, 9, 10, 1); set_node(4, 12, 11, 1); set_node(5, 10, 10, 1);
      run_search(10, 10, 2, 0);

      // Tie at distance 4: lower index wins.
      fill(100, 100, 1);
      set_node(3, 52, 52, 1); set_node(6, 48, 48, 1);
      run_search(50, 50, 1, 0);

      // Single valid node: no pair, outputs held.
      fill(0, 0, 0);
      set_node(4, 7, 7, 1);
      run_search(20, 20, 3, 0);

      // learning_done blocks start.
      @(negedge clk);
      learning_done = 1'b1;
      start = 1'b1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 3) start = 1'b0;
         if (rd_en || busy || done) bad = 1;
      end
      learning_done = 1'b0;
      check("learning_done_block", bad, 0);

      // Reset during the fourth SCAN cycle discards the search.
      fill(30, 30, 1);
      @(negedge clk);
      cur_class = 5; exp_rd_node = 1;
      class_in = 5; x_in = {8'd30, 8'd30}; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); @(posedge clk); @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outs", {node1, node2, class_i, dist1, en_connection, done, busy, no_pair, rd_en, rd_node, rd_class}, 0);
      prev_n1 = 0; prev_n2 = 0; prev_cls = 0; prev_d1 = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      set_node(1, 40, 40, 1); set_node(6, 31, 29, 1);
      run_search(30, 30, 5, 0);

      // Corner: distance 510 must not wrap.
      fill(0, 0, 0);
      set_node(1, 0, 0, 1); set_node(2, 255, 254, 1);
      run_search(255, 255, 7, 0);

      // Randomized searches; small value range makes ties common.
      for (int it = 0; it < 30; it++) begin
         if (it < 20) begin
            x0 = $urandom_range(0, 15); x1 = $urandom_range(0, 15);
            for (int n = 0; n < N; n++)
               set_node(n, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3) != 0);
         end else begin
            x0 = $urandom_range(0, 255); x1 = $urandom_range(0, 255);
            for (int n = 0; n < N; n++)
               set_node(n, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 2) == 0);
         end
         run_search(x0, x1, $urandom_range(0, 9), (it % 3) == 0);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/memory_layer_winner_search.md
MEMORY_LAYER_WINNER_SEARCH -- requirements
Module: memory_layer_winner_search

Interface
REQ-001 SHALL have parameter NODE_COUNT, default 8: node slots per class; slot 0 unused; scan covers 1..NODE_COUNT-1.
REQ-002 SHALL have parameter DIM, default 2: vector components.
REQ-003 SHALL have parameter DATA_W, default 8: unsigned bits per component.
REQ-004 SHALL have parameter DIST_W, default DATA_W+$clog2(DIM)+1: distance width.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  search request; sampled only in IDLE.
REQ-008 SHALL have port learning_done  input  1  when high, start is ignored.
REQ-009 SHALL have port class_in  input  32  class index searched; captured with start.
REQ-010 SHALL have port x_in  input  DIM*DATA_W  input vector, component d at bits [d*DATA_W +: DATA_W]; captured with start.
REQ-011 SHALL have port rd_en / rd_node / rd_class  output  1/32/32  node-memory read request.
REQ-012 SHALL have port rd_data / rd_node_valid  input  DIM*DATA_W / 1  weight vector and slot-valid flag, returned exactly one cycle after rd_en.
REQ-013 SHALL have port node1 / node2 / class_i  output  32/32/32  first winner, second winner, class; drive the connection memory.
REQ-014 SHALL have port en_connection  output  1  registered one-cycle pulse requesting a connection node1-node2.
REQ-015 SHALL have port busy / done / no_pair  output  1/1/1  search active; one-cycle completion pulse; fewer than two valid nodes found.
REQ-016 SHALL have port dist1  output  DIST_W  distance of node1.

Function
REQ-017 SHALL implement states IDLE, SCAN, DRAIN, REPORT.
REQ-018 IDLE -> SCAN when start=1 and learning_done=0; class_in and x_in are latched and best/second are cleared to index 0, distance all-ones.
REQ-019 SCAN: rd_en=1 for NODE_COUNT-1 consecutive cycles, rd_node=1,2,...,NODE_COUNT-1, rd_class=latched class; then DRAIN for 1 cycle, then REPORT for 1 cycle, then IDLE.
REQ-020 Distance SHALL be sum over d of |x[d]-w[d]|, computed unsigned at DIST_W bits with no overflow.
REQ-021 Each returned node with rd_node_valid=1: if d<best then second<=best, best<=(node,d); else if d<second then second<=(node,d). Strict compares; on ties the lower index wins.
REQ-022 Nodes with rd_node_valid=0 SHALL be skipped.
REQ-023 REPORT: if second index!=0 then node1, node2, class_i, dist1 update and en_connection=1 for exactly that cycle, no_pair=0; otherwise en_connection stays 0, no_pair=1, and node1/node2/class_i/dist1 hold their previous values.
REQ-024 done=1 for exactly the REPORT cycle.
REQ-025 busy=1 in SCAN, DRAIN and REPORT.
REQ-026 Latency: start sampled at edge 0; en_connection/done high in cycle NODE_COUNT+1; start is accepted again from cycle NODE_COUNT+2.
REQ-027 start while busy SHALL be ignored; learning_done rising mid-search does not abort it.
REQ-028 en_connection SHALL be flop-driven and glitch-free, since the consumer triggers on its rising edge; node1!=node2 is guaranteed whenever it pulses.
REQ-029 no_pair SHALL hold until the next REPORT.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and all outputs to 0 (node1, node2, class_i, dist1, en_connection, done, busy, no_pair, rd_en, rd_node, rd_class), including mid-search; the search is discarded.
REQ-031 After rst_n deasserts, the first start SHALL run a complete, correct search.

Verification (NODE_COUNT=8, DIM=2, DATA_W=8)
REQ-032 Stimulus: x=(10,10), class_in=2, all valid, w2=(9,10), w4=(12,11), w5=(10,10), others (200,200). Response: en_connection high in cycle 9 only; node1=5, node2=2, dist1=0, class_i=2.
REQ-033 Stimulus: nodes 3 and 6 both at distance 4, others farther. Response: node1=3, node2=6.
REQ-034 Stimulus: only node 4 valid. Response: no_pair=1, done pulses, en_connection never rises, node1/node2 unchanged.
REQ-035 Stimulus: start with learning_done=1. Response: rd_en, busy and done remain 0.
REQ-036 Stimulus: rst_n low during cycle 4 of SCAN, then a new search. Response: outputs 0 asynchronously, en_connection no pulse; new search gives correct winners.
REQ-037 Stimulus: x=(255,255), w1=(0,0), w2=(255,254), others invalid. Response: node1=2, node2=1, dist1=1; internal distance 510 without wrap.
